// File: rtl/sie_defs_pkg.sv
// Shared definitions for the USB full-speed serial interface engine:
// DPLL phase encoding and the default bus-idle timeout.
package sie_defs_pkg;

    // Width of the 4-phase sampling counter (48 MHz / 4 = 12 MHz).
    localparam int PHASE_W = 2;

    // Phase at which the recovered clock rises (mid-bit).
    localparam logic [PHASE_W-1:0] PHASE_MID = 2'd2;

    // Reload values: a transition seen only at the rising edge happened
    // just before it, so bit start is "now"; one already visible at the
    // preceding falling edge happened about a cycle earlier.
    localparam logic [PHASE_W-1:0] PHASE_EDGE  = 2'd0;
    localparam logic [PHASE_W-1:0] PHASE_EARLY = 2'd1;

    // 8 bit times: longer than six ones plus a stuffed zero.
    localparam int TIMEOUT_CYCLES_DEF = 32;

    // Width needed for a counter that saturates at 'limit'.
    function automatic int idle_cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage : sie_defs_pkg

// File: rtl/usb_dppl_edge_detect.sv
// D+ transition detector for the DPLL. Compares the current rising-edge
// sample against the previous one, and uses the falling-edge sample to
// tell whether the transition happened in the early half of the cycle.
module usb_dppl_edge_detect
    import sie_defs_pkg::*;
(
    input  logic clk48_i,
    input  logic rst_i,
    input  logic dpPosEdgeSync_i,
    input  logic dpNegEdgeSync_i,
    output logic edge_det_o,
    output logic early_o
);

    logic prev_sample_d;
    logic prev_sample_q;

    // Next previous-sample value and combinational edge classification.
    always_comb begin
        prev_sample_d = dpPosEdgeSync_i;
        edge_det_o    = (dpPosEdgeSync_i != prev_sample_q);
        // Falling-edge sample already shows the new level: early transition.
        early_o       = edge_det_o && (dpNegEdgeSync_i == dpPosEdgeSync_i);
    end

    // Previous D+ sample; idles at J (D+ high) out of reset.
    always_ff @(posedge clk48_i) begin
        if (rst_i) begin
            prev_sample_q <= 1'b1;
        end else begin
            prev_sample_q <= prev_sample_d;
        end
    end

endmodule : usb_dppl_edge_detect

// File: rtl/usb_dppl_clk_recovery.sv
// USB full-speed receive DPLL. A free-running 4-phase counter on the
// 48 MHz clock is re-aligned on every D+ transition so that the recovered
// 12 MHz clock (phase MSB) rises at mid-bit. An idle timer reports whether
// the bus is currently carrying transitions.
module usb_dppl_clk_recovery
    import sie_defs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
    input  logic clk48_i,
    input  logic rst_i,
    input  logic dpPosEdgeSync_i,
    input  logic dpNegEdgeSync_i,
    output logic readCLK12_o,
    output logic DPPLGotSignal_o
);

    localparam int               CNT_W   = idle_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic               edge_det;
    logic               early;

    logic [PHASE_W-1:0] phase_d;
    logic [PHASE_W-1:0] phase_q;
    logic [CNT_W-1:0]   idle_cnt_d;
    logic [CNT_W-1:0]   idle_cnt_q;
    logic               got_signal_d;
    logic               got_signal_q;

    usb_dppl_edge_detect u_edge_detect (
        .clk48_i         (clk48_i),
        .rst_i           (rst_i),
        .dpPosEdgeSync_i (dpPosEdgeSync_i),
        .dpNegEdgeSync_i (dpNegEdgeSync_i),
        .edge_det_o      (edge_det),
        .early_o         (early)
    );

    // Phase: reload on a transition, otherwise free-run with wrap 3 -> 0.
    always_comb begin
        phase_d = phase_q + PHASE_W'(1);
        if (edge_det) begin
            phase_d = early ? PHASE_EARLY : PHASE_EDGE;
        end
    end

    // Idle timer: cleared by a transition, saturates at the timeout.
    // A transition in the timeout cycle keeps the signal flag set.
    always_comb begin
        idle_cnt_d   = idle_cnt_q;
        got_signal_d = got_signal_q;
        if (edge_det) begin
            idle_cnt_d   = '0;
            got_signal_d = 1'b1;
        end else begin
            if (idle_cnt_q != CNT_MAX) begin
                idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
            if (idle_cnt_d == CNT_MAX) begin
                got_signal_d = 1'b0;
            end
        end
    end

    // State registers, all returning to the idle values on reset.
    always_ff @(posedge clk48_i) begin
        if (rst_i) begin
            phase_q      <= PHASE_EDGE;
            idle_cnt_q   <= '0;
            got_signal_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            idle_cnt_q   <= idle_cnt_d;
            got_signal_q <= got_signal_d;
        end
    end

    // Clock is high in phases PHASE_MID and above, i.e. the phase MSB,
    // straight from a flop so it cannot glitch.
    assign readCLK12_o     = phase_q[PHASE_W-1];
    assign DPPLGotSignal_o = got_signal_q;

endmodule : usb_dppl_clk_recovery

// File: tb/tb_usb_dppl_clk_recovery.sv
// Directed, table-driven bench for the USB DPLL clock recovery block.
module tb_usb_dppl_clk_recovery;

    logic clk48_i = 1'b0;
    logic rst_i;
    logic dpPosEdgeSync_i;
    logic dpNegEdgeSync_i;
    logic readCLK12_o;
    logic DPPLGotSignal_o;

    usb_dppl_clk_recovery #(.TIMEOUT_CYCLES(32)) dut (
        .clk48_i         (clk48_i),
        .rst_i           (rst_i),
        .dpPosEdgeSync_i (dpPosEdgeSync_i),
        .dpNegEdgeSync_i (dpNegEdgeSync_i),
        .readCLK12_o     (readCLK12_o),
        .DPPLGotSignal_o (DPPLGotSignal_o)
    );

    always #5 clk48_i = ~clk48_i;

    typedef struct {
        logic rst;
        logic pos;
        logic neg;
        logic exp_clk;
        logic exp_got;
    } vec_t;

    vec_t vecs[$];
    logic lvl;          // current D+ line level in the stimulus
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add_vec(input logic r, input logic p, input logic n,
                           input logic c, input logic g);
        vec_t v;
        v.rst = r; v.pos = p; v.neg = n; v.exp_clk = c; v.exp_got = g;
        vecs.push_back(v);
    endtask

    // One bit: transition to the opposite level, then hold for len cycles.
    // Cycle i counts from the cycle the edge is registered. A normal edge
    // reloads phase 0 (clock low, low, high, high), an early edge reloads 1.
    // The signal flag is 1 from the edge until 32 cycles of silence.
    task automatic add_bit(input int len, input bit is_early);
        logic nl;
        int   ph;
        nl = ~lvl;
        for (int i = 0; i < len; i++) begin
            ph = is_early ? (i + 1) % 4 : i % 4;
            add_vec(1'b0, nl, (i == 0) ? (is_early ? nl : lvl) : nl,
                    (ph >= 2), (i < 32));
        end
        lvl = nl;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        int n;
        string nm;

        // Reset with D+ idle, then 40 cycles of no activity: 0,0,1,1 ...
        add_vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 40; k++)
            add_vec(1'b0, 1'b1, 1'b1, ((k % 4) >= 2), 1'b0);
        lvl = 1'b1;
        // Regular toggling every 4 cycles.
        for (int k = 0; k < 4; k++) add_bit(4, 1'b0);
        // Early edges.
        add_bit(4, 1'b1);
        add_bit(4, 1'b1);
        // Jitter: periods alternating 3 and 5.
        for (int k = 0; k < 3; k++) begin
            add_bit(3, 1'b0);
            add_bit(5, 1'b0);
        end
        add_bit(3, 1'b1);
        // Timeout: 10 toggles, edge at 31, edge at 32, then silence.
        for (int k = 0; k < 10; k++) add_bit(4, 1'b0);
        add_bit(31, 1'b0);
        add_bit(32, 1'b0);
        add_bit(40, 1'b0);
        add_bit(4, 1'b0);   // reacquire after timeout
        // Reset with phase = 3 while active; D+ = 0 afterwards is an edge.
        add_bit(4, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        lvl = 1'b1;
        add_bit(4, 1'b0);
        add_bit(4, 1'b0);

        rst_i = 1'b1; dpPosEdgeSync_i = 1'b1; dpNegEdgeSync_i = 1'b1;
        foreach (vecs[i]) begin
            rst_i           = vecs[i].rst;
            dpPosEdgeSync_i = vecs[i].pos;
            dpNegEdgeSync_i = vecs[i].neg;
            @(posedge clk48_i);
            #1;
            nm = $sformatf("vec%0d readCLK12", i);
            check(nm, readCLK12_o, vecs[i].exp_clk);
            nm = $sformatf("vec%0d gotSignal", i);
            check(nm, DPPLGotSignal_o, vecs[i].exp_got);
        end

        // Hand sequence: one edge, then count cycles until the flag drops.
        dpPosEdgeSync_i = ~lvl;
        dpNegEdgeSync_i = lvl;
        @(posedge clk48_i);
        #1;
        check("seq edge gotSignal", DPPLGotSignal_o, 1'b1);
        check("seq edge readCLK12", readCLK12_o, 1'b0);
        dpNegEdgeSync_i = ~lvl;
        n = 0;
        while (n < 64) begin
            @(posedge clk48_i);
            #1;
            n++;
            if (n == 2) check("seq mid-bit rise", readCLK12_o, 1'b1);
            if (!DPPLGotSignal_o) break;
        end
        n_tests++;
        if (n != 32) begin
            n_fail++;
            $display("FAIL seq timeout length: got %0d cycles expected 32", n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_usb_dppl_clk_recovery
